// File: rtl/fifo_pkg.sv
// Shared sizing helpers for the 1R1W FIFO slice.
// Pointer and count widths are derived from the memory address width.
package fifo_pkg;

    function automatic int ptr_w(input int depth_log2);
        return depth_log2;
    endfunction

    function automatic int cnt_w(input int depth_log2);
        return depth_log2 + 1;
    endfunction

endpackage

// File: rtl/fifo_1r1w.sv
// Complete FIFO: the controller beside a 1R1W memory with a registered read port.
// Memory contents are never cleared; stale read data is masked by out_valid.
module fifo_1r1w
    import fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_data,
    output logic [DEPTH_LOG2:0] level
);

    localparam int PW       = ptr_w(DEPTH_LOG2);
    localparam int ELEMENTS = 2 ** DEPTH_LOG2;

    logic             mem_write;
    logic [PW-1:0]    mem_write_addr;
    logic [WIDTH-1:0] mem_write_data;
    logic             mem_read;
    logic [PW-1:0]    mem_read_addr;
    logic [WIDTH-1:0] mem_read_data;
    logic [WIDTH-1:0] storage [ELEMENTS];

    fifo_ctrl_1r1w #(
        .DEPTH_LOG2(DEPTH_LOG2),
        .WIDTH     (WIDTH)
    ) ctrl (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .level         (level),
        .mem_write     (mem_write),
        .mem_write_addr(mem_write_addr),
        .mem_write_data(mem_write_data),
        .mem_read      (mem_read),
        .mem_read_addr (mem_read_addr),
        .mem_read_data (mem_read_data)
    );

    // Read data holds its value while mem_read is low, which keeps the head stable.
    always_ff @(posedge clk) begin
        if (mem_write) begin
            storage[mem_write_addr] <= mem_write_data;
        end
        if (mem_read) begin
            mem_read_data <= storage[mem_read_addr];
        end
    end

endmodule

// File: rtl/fifo_ctrl_1r1w.sv
// First-word-fall-through FIFO controller driving an external 1R1W synchronous memory.
// The memory's read-data register acts as the output stage, so capacity is ELEMENTS+1.
module fifo_ctrl_1r1w
    import fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [DEPTH_LOG2:0]    level,
    output logic                   mem_write,
    output logic [DEPTH_LOG2-1:0]  mem_write_addr,
    output logic [WIDTH-1:0]       mem_write_data,
    output logic                   mem_read,
    output logic [DEPTH_LOG2-1:0]  mem_read_addr,
    input  logic [WIDTH-1:0]       mem_read_data
);

    localparam int PW = ptr_w(DEPTH_LOG2);
    localparam int CW = cnt_w(DEPTH_LOG2);
    localparam logic [CW-1:0] ELEMENTS = CW'(2 ** DEPTH_LOG2);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] mem_cnt;
    logic          head_valid;
    logic          clear;
    logic          push;
    logic          pop;
    logic          fetch;

    assign clear    = rst || flush;
    assign in_ready = !clear && (mem_cnt != ELEMENTS);
    assign push     = in_valid && in_ready;
    assign pop      = head_valid && out_ready;

    // mem_cnt excludes the word written this cycle, so a fetch never reads a live write address.
    assign fetch    = (mem_cnt != '0) && (!head_valid || out_ready) && !clear;

    assign mem_write      = push;
    assign mem_write_addr = wr_ptr;
    assign mem_write_data = in_data;
    assign mem_read       = fetch;
    assign mem_read_addr  = rd_ptr;

    assign out_valid = head_valid;
    assign out_data  = mem_read_data;
    assign level     = mem_cnt + {{(CW-1){1'b0}}, head_valid};

    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            mem_cnt    <= '0;
            head_valid <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (fetch) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            mem_cnt <= mem_cnt + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, fetch};
            if (fetch) begin
                head_valid <= 1'b1;
            end else if (pop) begin
                head_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/fifo_ctrl_1r1w.md
Name: fifo_ctrl_1r1w

Overview:
- Synchronous first-word-fall-through (FWFT) FIFO controller with valid/ready on both sides.
- Sits directly upstream of the team's 1-read/1-write synchronous memory: drives its write port and read port, and consumes its registered read data.
- The memory is external; a top-level wrapper instantiates the controller and the memory side by side.
- The memory's read-data register serves as the output holding stage, so no extra data flops are needed.

Parameters:
- DEPTH_LOG2, default 4: memory address width; memory holds ELEMENTS = 2**DEPTH_LOG2 words.
- WIDTH, default 32: data width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of all FIFO state; same effect as rst on this block.
- in_valid  in  1  producer has a word.
- in_ready  out  1  controller accepts a word this cycle.
- in_data  in  WIDTH  producer word.
- out_valid  out  1  out_data holds the FIFO head.
- out_ready  in  1  consumer takes the head this cycle.
- out_data  out  WIDTH  head word; direct combinational passthrough of mem_read_data.
- level  out  DEPTH_LOG2+1  occupancy, 0..ELEMENTS+1.
- mem_write  out  1  memory write enable.
- mem_write_addr  out  DEPTH_LOG2  memory write address.
- mem_write_data  out  WIDTH  memory write data; equals in_data.
- mem_read  out  1  memory read enable.
- mem_read_addr  out  DEPTH_LOG2  memory read address.
- mem_read_data  in  WIDTH  memory read data; valid 1 cycle after mem_read, held while mem_read=0.

Behaviour:
- State:
  - wr_ptr, rd_ptr: DEPTH_LOG2 bits each; wrap modulo ELEMENTS naturally.
  - mem_cnt: DEPTH_LOG2+1 bits; words in memory not yet fetched.
  - out_valid flop.
- Push = in_valid && in_ready.
- in_ready = !rst && !flush && (mem_cnt != ELEMENTS).
- Write path:
  - mem_write = push.
  - mem_write_addr = wr_ptr.
  - On push, wr_ptr increments.
- Pop = out_valid && out_ready.
- Fetch = (mem_cnt != 0) && (!out_valid || out_ready) && !rst && !flush.
- Read path:
  - mem_read = fetch.
  - mem_read_addr = rd_ptr.
  - On fetch, rd_ptr increments.
- out_valid next state = fetch ? 1 : (pop ? 0 : out_valid).
- mem_cnt next state = mem_cnt + push - fetch.
- level = mem_cnt + out_valid. Total capacity is ELEMENTS+1, because the fetched word lives in the memory's read register and its slot is already freed.
- Latency:
  - Push at cycle t into an empty FIFO: mem_cnt=1 at t+1, fetch at t+1, out_valid=1 at t+2.
  - Steady state with push and pop every cycle: one word per cycle, no bubbles.
- Collision rule: the word written in cycle t is never fetched in cycle t (mem_cnt excludes it). Hence read and write addresses never alias on a live entry, and the memory's read-during-write ordering is irrelevant.
- Full (mem_cnt == ELEMENTS): in_ready=0.
  - A simultaneous fetch frees a slot only from the next cycle on; in_ready stays a function of the registered mem_cnt (no combinational ready path from out_ready).
- Empty (mem_cnt == 0, !out_valid):
  - no mem_read;
  - out_data is don't-care.
- out_data must stay stable while out_valid && !out_ready. Guaranteed because no fetch occurs in that state.
- Reset/flush (including mid-operation):
  - next cycle: wr_ptr=0, rd_ptr=0, mem_cnt=0, out_valid=0, level=0.
  - during the asserted cycle: in_ready=0, mem_write=0, mem_read=0.
  - A push or fetch coincident with rst/flush is dropped.
  - After rst/flush deasserts, in_ready=1.
- Memory contents are not cleared; stale mem_read_data after reset is masked by out_valid=0.

Decomposition:
- Shared package fifo_pkg:
  - function ptr_w(depth_log2) returning DEPTH_LOG2;
  - function cnt_w(depth_log2) returning DEPTH_LOG2+1.
- No sub-module needed. Pointer/count logic stays inline.
- Top wrapper fifo_1r1w (separate file) instantiates fifo_ctrl_1r1w plus the 1R1W memory.

Test Plan:
- Reset then single word: push 0xA5A5_0001 at t0 -> out_valid=1 with out_data=0xA5A5_0001 at t0+2; level 1 at t0+1, 1 at t0+2; pop -> level 0, out_valid=0.
- Fill, out_ready=0, DEPTH_LOG2=4:
  - 17 pushes of values 0..16 accepted; in_ready=0 when level=17;
  - 18th push stalls;
  - drain yields 0..16 in order, each held stable while out_ready=0.
- Streaming: in_valid=out_ready=1 for 100 cycles with an incrementing pattern -> after 2-cycle fill, one output per cycle, no gaps, level constant 1–2, no data loss.
- Wrap-around: push/pop 3×ELEMENTS words with random out_ready backpressure -> output sequence equals input sequence; pointers wrap through 15->0 without error.
- Flush mid-operation:
  - level=9 with push and fetch active; flush for 1 cycle -> next cycle level=0, out_valid=0, in_ready=1, no mem_write/mem_read during the flush cycle;
  - a subsequent push of 0xDEAD_BEEF emerges first.
- Backpressure at full: level=17, out_ready=1 for one cycle -> in_ready rises exactly one cycle later; no overwrite of unread entries (checked against a scoreboard).
